// File: rtl/lsu_mem_stage.sv
// Load/store stage: drives a req/ack data-memory port from the EX-stage address and returns extended load data.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of being aligned down.
module lsu_mem_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic                    ex_mem_read,
    input  logic                    ex_mem_write,
    input  logic [2:0]              ex_funct3,
    input  logic [DATA_WIDTH-1:0]   ex_addr,
    input  logic [DATA_WIDTH-1:0]   ex_store_data,
    input  logic [4:0]              ex_rd,
    output logic                    stall,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [3:0]              dmem_be,
    output logic [DATA_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic                    dmem_ack,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    wb_valid,
    output logic [4:0]              wb_rd,
    output logic [DATA_WIDTH-1:0]   wb_data,
    output logic                    misalign_fault
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t                  r_state, w_next;
    size_t                   w_size, r_size;
    logic                    w_unsigned, r_unsigned;
    logic                    w_accept, w_misalign;
    logic [3:0]              w_be, r_be;
    logic [DATA_WIDTH-1:0]   w_wdata, r_wdata, r_addr;
    logic [DATA_WIDTH-1:0]   w_load_ext, r_wb_data;
    logic [1:0]              r_lane;
    logic [4:0]              r_rd, r_wb_rd;
    logic                    r_we, r_is_load, r_wb_valid;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;

    // Size, byte-enable and lane-replicated store data for the instruction on the EX inputs
    always_comb begin
        w_size     = SZ_WORD;
        w_unsigned = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = ex_store_data;
        case (ex_funct3)
            3'b000:  w_size = SZ_BYTE;
            3'b001:  w_size = SZ_HALF;
            3'b100:  begin w_size = SZ_BYTE; w_unsigned = 1'b1; end
            3'b101:  begin w_size = SZ_HALF; w_unsigned = 1'b1; end
            default: w_size = SZ_WORD;
        endcase
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << ex_addr[1:0];
                w_wdata = {4{ex_store_data[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << {ex_addr[1], 1'b0};
                w_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ex_store_data;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SZ_HALF) && ex_addr[0]) ||
                        ((w_size == SZ_WORD) && (ex_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // rst gates accept so stall drops the moment reset asserts, even with an instruction still presented
    assign w_accept = !rst && (r_state == IDLE) && ex_valid && (ex_mem_read || ex_mem_write);
    assign stall    = w_accept || (r_state == BUSY);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_misalign ? RESP : BUSY;
            BUSY:    if (dmem_ack) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_is_load  <= 1'b0;
            r_rd       <= '0;
            r_lane     <= '0;
            r_size     <= SZ_WORD;
            r_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= {ex_addr[DATA_WIDTH-1:2], 2'b00};
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_we       <= ex_mem_write && !ex_mem_read;
            r_is_load  <= ex_mem_read;
            r_rd       <= ex_rd;
            r_lane     <= ex_addr[1:0];
            r_size     <= w_size;
            r_unsigned <= w_unsigned;
        end
    end

    // Lane select on the raw read word; misaligned halfwords fall back to addr[1] only
    always_comb begin
        w_byte     = dmem_rdata[{r_lane, 3'b000} +: 8];
        w_half     = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_ext = dmem_rdata;
        case (r_size)
            SZ_BYTE: w_load_ext = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load_ext = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if ((r_state == BUSY) && dmem_ack && r_is_load) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                r_wb_data  <= w_load_ext;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_fault;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fault <= 1'b0;
        else     r_fault <= w_accept && w_misalign;
    end
    assign misalign_fault = r_fault;
`else
    assign misalign_fault = 1'b0;
`endif

    assign dmem_req   = (r_state == BUSY);
    assign dmem_we    = r_we && (r_state == BUSY);
    assign dmem_be    = r_be;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage; inputs change and outputs are sampled 1-2 ns after the rising edge.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data;
    logic [4:0]  ex_rd;
    logic        stall, dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_fault;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en;
        ex_funct3 = f3; ex_addr = a; ex_store_data = d; ex_rd = r;
        #1;
    endtask

    task automatic retire();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = '0; ex_addr = '0; ex_store_data = '0; ex_rd = '0;
        #3;
        checks++; if ({stall, dmem_req, dmem_we, wb_valid, misalign_fault} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {stall, dmem_req, dmem_we, wb_valid, misalign_fault}); end
        checks++; if ({dmem_be, dmem_addr, dmem_wdata, wb_rd, wb_data} !== '0) begin
            errors++; $display("FAIL reset_data be=%h addr=%h wdata=%h rd=%h data=%h exp all 0",
                               dmem_be, dmem_addr, dmem_wdata, wb_rd, wb_data); end
        present(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd1);
        tick();
        checks++; if ({stall, dmem_req} !== 2'b00) begin
            errors++; $display("FAIL reset_hold_accept stall/req got %b exp 00", {stall, dmem_req}); end
        retire();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lw_immediate();
        present(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
        checks++; if ({stall, dmem_req} !== 2'b10) begin
            errors++; $display("FAIL lw_accept stall/req got %b exp 10", {stall, dmem_req}); end
        tick();
        checks++; if ({stall, dmem_req, dmem_we, dmem_be, dmem_addr} !== {3'b110, 4'b1111, 32'h100}) begin
            errors++; $display("FAIL lw_busy stall/req/we=%b be=%b addr=%h exp 110 1111 00000100",
                               {stall, dmem_req, dmem_we}, dmem_be, dmem_addr); end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        tick();
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL lw_resp valid=%b rd=%0d data=%h exp 1 5 deadbeef", wb_valid, wb_rd, wb_data); end
        checks++; if ({stall, dmem_req} !== 2'b00) begin
            errors++; $display("FAIL lw_resp_stall stall/req got %b exp 00", {stall, dmem_req}); end
        dmem_ack = 1'b0; retire();
        tick();
        checks++; if ({wb_valid, stall, dmem_req} !== 3'b000) begin
            errors++; $display("FAIL lw_idle valid/stall/req got %b exp 000", {wb_valid, stall, dmem_req}); end
    endtask

    task automatic test_lb_delayed(input logic [2:0] f3, input logic [31:0] exp_data);
        present(1'b1, 1'b0, f3, 32'h103, 32'h0, 5'd7);
        tick();
        checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr} !== {2'b10, 4'b1000, 32'h100}) begin
            errors++; $display("FAIL lb_busy f3=%b req/we=%b be=%b addr=%h exp 10 1000 00000100",
                               f3, {dmem_req, dmem_we}, dmem_be, dmem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({stall, dmem_req, dmem_be, dmem_addr, wb_valid} !== {2'b11, 4'b1000, 32'h100, 1'b0}) begin
                errors++; $display("FAIL lb_wait%0d stall/req=%b be=%b addr=%h valid=%b exp 11 1000 00000100 0",
                                   i, {stall, dmem_req}, dmem_be, dmem_addr, wb_valid); end
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h80123456;
        tick();
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, exp_data}) begin
            errors++; $display("FAIL lb_resp f3=%b valid=%b rd=%0d data=%h exp 1 7 %h", f3, wb_valid, wb_rd, wb_data, exp_data); end
        dmem_ack = 1'b0; retire();
        tick();
    endtask

    task automatic test_sh();
        present(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd3);
        checks++; if (stall !== 1'b1) begin
            errors++; $display("FAIL sh_accept stall got %b exp 1", stall); end
        tick();
        checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {2'b11, 4'b1100, 32'h200, 32'hABCDABCD}) begin
            errors++; $display("FAIL sh_busy req/we=%b be=%b addr=%h wdata=%h exp 11 1100 00000200 abcdabcd",
                               {dmem_req, dmem_we}, dmem_be, dmem_addr, dmem_wdata); end
        dmem_ack = 1'b1;
        tick();
        checks++; if ({wb_valid, stall, dmem_req, dmem_we} !== 4'b0000) begin
            errors++; $display("FAIL sh_resp valid/stall/req/we got %b exp 0000", {wb_valid, stall, dmem_req, dmem_we}); end
        dmem_ack = 1'b0; retire();
        tick();
    endtask

    task automatic test_misalign();
        present(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd9);
        checks++; if (stall !== 1'b1) begin
            errors++; $display("FAIL mis_accept stall got %b exp 1", stall); end
        tick();
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if ({dmem_req, misalign_fault, wb_valid, stall} !== 4'b0100) begin
            errors++; $display("FAIL mis_fault req/fault/valid/stall got %b exp 0100",
                               {dmem_req, misalign_fault, wb_valid, stall}); end
        retire();
        tick();
        checks++; if ({dmem_req, misalign_fault} !== 2'b00) begin
            errors++; $display("FAIL mis_after req/fault got %b exp 00", {dmem_req, misalign_fault}); end
`else
        checks++; if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'b1111, 32'h100}) begin
            errors++; $display("FAIL mis_align_down req=%b be=%b addr=%h exp 1 1111 00000100", dmem_req, dmem_be, dmem_addr); end
        dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
        tick();
        checks++; if ({wb_valid, misalign_fault, wb_data} !== {2'b10, 32'h11223344}) begin
            errors++; $display("FAIL mis_resp valid/fault=%b data=%h exp 10 11223344", {wb_valid, misalign_fault}, wb_data); end
        dmem_ack = 1'b0; retire();
        tick();
`endif
    endtask

    task automatic test_reset_mid_busy();
        present(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd12);
        tick();
        checks++; if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL rmb_busy req got %b exp 1", dmem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin
            errors++; $display("FAIL rmb_async req/stall got %b exp 00", {dmem_req, stall}); end
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        tick();
        checks++; if ({wb_valid, dmem_req} !== 2'b00) begin
            errors++; $display("FAIL rmb_in_reset valid/req got %b exp 00", {wb_valid, dmem_req}); end
        retire();
        rst = 1'b0;
        tick();
        checks++; if ({wb_valid, dmem_req, stall} !== 3'b000) begin
            errors++; $display("FAIL rmb_late_ack valid/req/stall got %b exp 000", {wb_valid, dmem_req, stall}); end
        dmem_ack = 1'b0;
        present(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 5'd13);
        tick();
        checks++; if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'b1100, 32'h300}) begin
            errors++; $display("FAIL rmb_next_busy req=%b be=%b addr=%h exp 1 1100 00000300", dmem_req, dmem_be, dmem_addr); end
        dmem_ack = 1'b1; dmem_rdata = 32'h80015555;
        tick();
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd13, 32'hFFFF8001}) begin
            errors++; $display("FAIL rmb_next_resp valid=%b rd=%0d data=%h exp 1 13 ffff8001", wb_valid, wb_rd, wb_data); end
        dmem_ack = 1'b0; retire();
        tick();
    endtask

    task automatic test_back_to_back();
        present(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h01020304;
        tick();
        checks++; if ({wb_valid, wb_data} !== {1'b1, 32'h01020304}) begin
            errors++; $display("FAIL b2b_first valid=%b data=%h exp 1 01020304", wb_valid, wb_data); end
        dmem_ack = 1'b0;
        present(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 5'd2);
        checks++; if (stall !== 1'b0) begin
            errors++; $display("FAIL b2b_resp_ignore stall got %b exp 0", stall); end
        tick();
        checks++; if ({stall, dmem_req, wb_valid} !== 3'b100) begin
            errors++; $display("FAIL b2b_second_accept stall/req/valid got %b exp 100", {stall, dmem_req, wb_valid}); end
        tick();
        checks++; if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'b0010, 32'h10}) begin
            errors++; $display("FAIL b2b_second_busy req=%b be=%b addr=%h exp 1 0010 00000010", dmem_req, dmem_be, dmem_addr); end
        dmem_ack = 1'b1; dmem_rdata = 32'h0102F304;
        tick();
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 32'h000000F3}) begin
            errors++; $display("FAIL b2b_second_resp valid=%b rd=%0d data=%h exp 1 2 000000f3", wb_valid, wb_rd, wb_data); end
        dmem_ack = 1'b0; retire();
        tick();
        checks++; if ({wb_valid, dmem_req, stall} !== 3'b000) begin
            errors++; $display("FAIL b2b_idle valid/req/stall got %b exp 000", {wb_valid, dmem_req, stall}); end
    endtask

    initial begin
        test_reset();
        test_lw_immediate();
        test_lb_delayed(3'b000, 32'hFFFFFF80);
        test_lb_delayed(3'b100, 32'h00000080);
        test_sh();
        test_misalign();
        test_reset_mid_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store stage directly downstream of the EX-stage ALU. It takes the ALU result as the effective address and drives a request/acknowledge data-memory port. It stalls the pipeline while an access is outstanding, then returns sign- or zero-extended load data to writeback. Non-memory instructions pass through untouched; the block only acts on loads and stores.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: data and address width. Only 32 is supported.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `ex_valid`, in, 1: an instruction is present from EX.
- `ex_mem_read`, in, 1: the instruction is a load.
- `ex_mem_write`, in, 1: the instruction is a store.
- `ex_funct3`, in, 3: access size and signedness.
- `ex_addr`, in, 32: effective address (ALU `output_data`).
- `ex_store_data`, in, 32: rs2 value for stores.
- `ex_rd`, in, 5: load destination register.
- `stall`, out, 1: holds the upstream pipeline.
- `dmem_req`, out, 1: memory request.
- `dmem_we`, out, 1: 1 for a write.
- `dmem_be`, out, 4: byte enables.
- `dmem_addr`, out, 32: word-aligned address, with `[1:0]` = 0.
- `dmem_wdata`, out, 32: lane-replicated store data.
- `dmem_ack`, in, 1: memory completes the request.
- `dmem_rdata`, in, 32: read word, valid with `dmem_ack`.
- `wb_valid`, out, 1: one-cycle pulse; load result is valid.
- `wb_rd`, out, 5: destination register.
- `wb_data`, out, 32: extended load data.
- `misalign_fault`, out, 1: one-cycle pulse on a misaligned access.

## Operation
- The FSM has three states: IDLE, BUSY and RESP. Reset returns it to IDLE.
- **Accept:** in IDLE, the block accepts when `ex_valid & (ex_mem_read | ex_mem_write)`.
  - If both read and write are set, the access is treated as a load.
  - On accept, the block registers the address, size, data and `rd`, and moves to BUSY.
- **Size decode** (from `ex_funct3`):
  - 000 is a byte access.
  - 001 is a halfword access.
  - 010 is a word access.
  - 100 is LBU; 101 is LHU.
  - Any other code is treated as a word access.
- **Byte enables:**
  - Byte: `dmem_be` = `4'b0001 << addr[1:0]`.
  - Halfword: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
- **Store data:** `dmem_wdata` is the byte replicated ×4 for byte stores, the halfword replicated ×2 for halfword stores, or the full word.
- **BUSY:** `dmem_req` = 1. The outputs `dmem_we`, `dmem_be`, `dmem_addr` and `dmem_wdata` are held stable until `dmem_ack`. On ack, a load captures `dmem_rdata`, then the FSM moves to RESP.
- **RESP (one cycle):**
  - `wb_valid` = 1 for loads and 0 for stores.
  - `wb_data` is the lane selected by the latched `addr[1:0]`. It is sign-extended for funct3 000/001 and zero-extended for 100/101.
  - The FSM then returns to IDLE.
  - Inputs are ignored in RESP, so the still-present stalled instruction is not re-accepted.
- **Stall:** `stall` = (IDLE & accept) | BUSY. It is combinational and low in RESP, so the upstream pipeline advances at the end of RESP.
- **Ack in IDLE or RESP:** ignored.

## Timing
- **Reset values:** `stall`, `dmem_req`, `dmem_we`, `wb_valid` and `misalign_fault` are 0. `dmem_be`, `dmem_addr`, `dmem_wdata`, `wb_rd` and `wb_data` are 0. State is IDLE.
- **Latency:**
  - Cycle T: accept, `stall` = 1.
  - Cycle T+1: `dmem_req` = 1 (registered).
  - Cycle T+1+k: `dmem_ack`, for k ≥ 0. An ack in the first request cycle is legal.
  - Cycle T+2+k: RESP, `wb_valid` = 1, `stall` = 0.
  - Minimum occupancy is 3 cycles.
- **Handshake:** `dmem_req` deasserts in the cycle after `dmem_ack`. There is never more than one outstanding request.
- **Reset mid-operation:** asserting `rst` drops `dmem_req` and `stall` immediately, without waiting for a clock edge. An ack arriving after reset is ignored.
- **Registered outputs:** `wb_*` and `misalign_fault` are registered, each valid for exactly one cycle.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - A misaligned access is a halfword with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0.
  - Such an access goes IDLE→RESP directly and issues no memory request.
  - In RESP: `misalign_fault` = 1, `wb_valid` = 0, and `stall` is high only in the accept cycle.
- **Undefined:**
  - `misalign_fault` is tied to 0.
  - Misaligned accesses are aligned down: halfwords ignore `addr[0]`, and words ignore `addr[1:0]` for lane selection.

## Test plan
- **LW, immediate ack:** `ex_addr` = 0x100, ack in the first req cycle with rdata 0xDEADBEEF. Expect `dmem_addr` = 0x100, `be` = 1111, `stall` high 2 cycles, and `wb_valid` at T+2 with `wb_data` = 0xDEADBEEF.
- **LB and LBU, delayed ack:** addr 0x103, rdata 0x80xxxxxx, ack after 3 wait cycles. Expect `be` = 1000 and `wb_data` = 0xFFFFFF80 (LB) or 0x00000080 (LBU); `req` is held stable through the wait.
- **SH:** addr 0x202, data 0x1234ABCD. Expect `dmem_we` = 1, `be` = 1100, `wdata` = 0xABCDABCD, and `wb_valid` = 0 in RESP.
- **Misaligned LW at 0x101:**
  - With the macro: no `dmem_req`, and a `misalign_fault` pulse at T+1.
  - Without: a request to 0x100 with `be` = 1111.
- **Reset mid-BUSY:** assert `rst` while `dmem_req` = 1, then ack. Expect `req` and `stall` to drop asynchronously, no `wb_valid`, and the next load to complete normally.
